// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter that shares one 32-bit ALU between
//               NUM_REQ requesters. It registers the operands and the results,
//               and uses valid/ready handshakes on the request and response sides.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [3*NUM_REQ-1:0]  i_req_cmd,
    input  logic [32*NUM_REQ-1:0] i_req_a,
    input  logic [32*NUM_REQ-1:0] i_req_b,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic [31:0]           o_rsp_result,
    output logic                  o_rsp_carryout,
    output logic                  o_rsp_zero,
    output logic                  o_rsp_overflow,
    output logic [CNT_W-1:0]      o_ops_done
);

    localparam logic [2:0] C_ADD  = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_XOR  = 3'd2;
    localparam logic [2:0] C_SLT  = 3'd3;
    localparam logic [2:0] C_AND  = 3'd4;
    localparam logic [2:0] C_NAND = 3'd5;
    localparam logic [2:0] C_NOR  = 3'd6;
    localparam logic [2:0] C_OR   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [2:0]       r_op_cmd;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [ID_W-1:0]  r_op_id;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [31:0]      r_rsp_result;
    logic             r_rsp_cout;
    logic             r_rsp_zero;
    logic             r_rsp_ovf;
    logic [CNT_W-1:0] r_ops_done;

    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_next_ptr;
    int               w_idx;

    logic [31:0]      w_b_eff;
    logic [32:0]      w_sum;
    logic             w_add_ovf;
    logic [31:0]      w_alu_result;
    logic             w_alu_cout;
    logic             w_alu_ovf;
    logic             w_alu_zero;

    // Round-robin search: first valid requester starting at r_rr_ptr, wrapping at NUM_REQ
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && i_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_W-1:0];
            end
        end
        w_next_ptr = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    end

    // Grant is one-hot on the winner and only offered while idle
    always_comb begin
        o_req_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            o_req_ready[w_winner] = 1'b1;
        end
    end

    // ALU: SUB and SLT share the adder as a + ~b + 1; flags are only meaningful for ADD/SUB
    always_comb begin
        w_b_eff      = (r_op_cmd == C_ADD) ? r_op_b : ~r_op_b;
        w_sum        = {1'b0, r_op_a} + {1'b0, w_b_eff} + {32'd0, (r_op_cmd != C_ADD)};
        w_add_ovf    = (r_op_a[31] == w_b_eff[31]) && (w_sum[31] != r_op_a[31]);
        w_alu_result = '0;
        w_alu_cout   = 1'b0;
        w_alu_ovf    = 1'b0;
        case (r_op_cmd)
            C_ADD, C_SUB: begin
                w_alu_result = w_sum[31:0];
                w_alu_cout   = w_sum[32];
                w_alu_ovf    = w_add_ovf;
            end
            C_SLT:   w_alu_result = {31'd0, w_sum[31] ^ w_add_ovf};
            C_XOR:   w_alu_result = r_op_a ^ r_op_b;
            C_AND:   w_alu_result = r_op_a & r_op_b;
            C_NAND:  w_alu_result = ~(r_op_a & r_op_b);
            C_NOR:   w_alu_result = ~(r_op_a | r_op_b);
            C_OR:    w_alu_result = r_op_a | r_op_b;
            default: w_alu_result = '0;
        endcase
        w_alu_zero = (w_alu_result == 32'd0);
    end

    // Control FSM: accept in IDLE, let the ALU settle in EXEC, hold the response in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_op_cmd     <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_id      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_ops_done   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op_cmd <= i_req_cmd[3*w_winner +: 3];
                        r_op_a   <= i_req_a[32*w_winner +: 32];
                        r_op_b   <= i_req_b[32*w_winner +: 32];
                        r_op_id  <= w_winner;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= w_alu_result;
                    r_rsp_cout   <= w_alu_cout;
                    r_rsp_zero   <= w_alu_zero;
                    r_rsp_ovf    <= w_alu_ovf;
                    r_rsp_id     <= r_op_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_id       = r_rsp_id;
    assign o_rsp_result   = r_rsp_result;
    assign o_rsp_carryout = r_rsp_cout;
    assign o_rsp_zero     = r_rsp_zero;
    assign o_rsp_overflow = r_rsp_ovf;
    assign o_ops_done     = r_ops_done;

endmodule
`default_nettype wire
